// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// The slave modport is the unit itself; the master modport is the
// execute stage plus data memory that surround it.
interface load_store_unit_if;
  // request from execute
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  // completion
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_fault;
  logic [31:0] fault_addr;
  // data memory
  logic [3:0]  wmem;
  logic [4:0]  rmem;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, load_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_fault, fault_addr,
           wmem, rmem, mem_addr, store_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, load_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_fault, fault_addr,
           wmem, rmem, mem_addr, store_data
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit. Accepts one request at a time,
// rejects misaligned or illegal accesses with a one-cycle fault response,
// and performs sub-word stores as read-modify-write of the whole word.
// Memory-side outputs depend only on state and latched request fields.
module load_store_unit #(
  parameter int ADDR_WIDTH = 15
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    STORE_W = 3'd2,
    RMW_RD  = 3'd3,
    RMW_WR  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [4:0]            rd_q, rd_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [31:0]           merge_q, merge_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [4:0]            rsp_rd_q, rsp_rd_d;
  logic                  rsp_fault_q, rsp_fault_d;
  logic [31:0]           fault_addr_q, fault_addr_d;

  logic [1:0]  byte_off;
  logic [31:0] word_addr;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic        req_illegal;
  logic        req_misalign;

  assign byte_off  = addr_q[1:0];
  // Upper address bits beyond the implemented memory are dropped, so they alias.
  assign word_addr = {{(32-ADDR_WIDTH){1'b0}}, addr_q[ADDR_WIDTH+1:2]};

  // Fault decode on the incoming request.
  always_comb begin
    req_illegal  = 1'b0;
    req_misalign = 1'b0;
    if (bus.req_we) begin
      req_illegal = (bus.req_funct3 > 3'b010);
    end else begin
      req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    end
    if (bus.req_funct3[1:0] == 2'b01) begin
      req_misalign = bus.req_addr[0];
    end else if (bus.req_funct3[1:0] == 2'b10) begin
      req_misalign = (bus.req_addr[1:0] != 2'b00);
    end
  end

  // Lane extraction and sign/zero extension of the returned load word.
  always_comb begin
    shifted  = bus.load_data >> {byte_off, 3'b000};
    load_ext = bus.load_data;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = bus.load_data;
    endcase
  end

  // Replace the target byte or halfword of the previously read word.
  always_comb begin
    merged = merge_q;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{byte_off, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{byte_off[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end

  // State register and latched request/response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      funct3_q     <= '0;
      merge_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_rd_q     <= '0;
      rsp_fault_q  <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      merge_q      <= merge_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_rd_q     <= rsp_rd_d;
      rsp_fault_q  <= rsp_fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Next-state logic, response generation and memory-side outputs.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_d           = rd_q;
    funct3_d       = funct3_q;
    merge_d        = merge_q;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_rd_d       = rsp_rd_q;
    rsp_fault_d    = rsp_fault_q;
    fault_addr_d   = fault_addr_q;
    bus.req_ready  = 1'b0;
    bus.wmem       = 4'b0000;
    bus.rmem       = 5'b00000;
    bus.mem_addr   = 32'd0;
    bus.store_data = 32'd0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d   = bus.req_addr[ADDR_WIDTH+1:0];
          wdata_d  = bus.req_wdata;
          rd_d     = bus.req_rd;
          funct3_d = bus.req_funct3;
          if (req_illegal || req_misalign) begin
            rsp_valid_d  = 1'b1;
            rsp_fault_d  = 1'b1;
            rsp_rdata_d  = 32'd0;
            rsp_rd_d     = bus.req_rd;
            fault_addr_d = bus.req_addr;
          end else if (!bus.req_we) begin
            state_d = LOAD;
          end else if (bus.req_funct3[1:0] == 2'b10) begin
            state_d = STORE_W;
          end else begin
            state_d = RMW_RD;
          end
        end
      end

      LOAD: begin
        bus.mem_addr = word_addr;
        case (funct3_q[1:0])
          2'b00:   bus.rmem = {~funct3_q[2], 4'b0001 << byte_off};
          2'b01:   bus.rmem = {~funct3_q[2], byte_off[1] ? 4'b1100 : 4'b0011};
          default: bus.rmem = 5'b01111;
        endcase
        rsp_valid_d = 1'b1;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = load_ext;
        rsp_rd_d    = rd_q;
        state_d     = IDLE;
      end

      STORE_W: begin
        bus.mem_addr   = word_addr;
        bus.wmem       = 4'b1111;
        bus.store_data = wdata_q;
        rsp_valid_d    = 1'b1;
        rsp_fault_d    = 1'b0;
        rsp_rdata_d    = 32'd0;
        rsp_rd_d       = rd_q;
        state_d        = IDLE;
      end

      RMW_RD: begin
        bus.mem_addr = word_addr;
        bus.rmem     = 5'b01111;
        merge_d      = bus.load_data;
        state_d      = RMW_WR;
      end

      RMW_WR: begin
        bus.mem_addr   = word_addr;
        bus.wmem       = 4'b1111;
        bus.store_data = merged;
        rsp_valid_d    = 1'b1;
        rsp_fault_d    = 1'b0;
        rsp_rdata_d    = 32'd0;
        rsp_rd_d       = rd_q;
        state_d        = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_rd     = rsp_rd_q;
  assign bus.rsp_fault  = rsp_fault_q;
  assign bus.fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide memory model and a
// response scoreboard: expectations are queued when a request is accepted
// and popped when the unit raises rsp_valid.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.ADDR_WIDTH(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory model: combinational read, byte-strobed write at the edge.
  logic [31:0] mem [0:255];
  assign bus.load_data = mem[bus.mem_addr[7:0]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.wmem[b]) mem[bus.mem_addr[7:0]][8*b +: 8] <= bus.store_data[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        fault;
    logic [31:0] faddr;
    int          cyc;
  } exp_t;
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  // strobe observations of the current transaction
  int          n_rd, n_wr;
  logic [4:0]  last_rmem;
  logic [3:0]  last_wmem;
  logic [31:0] last_raddr, last_waddr, last_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample_strobes();
    if (bus.rmem != 5'd0) begin
      n_rd++; last_rmem = bus.rmem; last_raddr = bus.mem_addr;
    end
    if (bus.wmem != 4'd0) begin
      n_wr++; last_wmem = bus.wmem; last_waddr = bus.mem_addr; last_wdata = bus.store_data;
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                      input logic [31:0] exp_rdata, input logic exp_fault, input int lat,
                      input int exp_nrd, input logic [4:0] exp_rmem,
                      input int exp_nwr, input logic [31:0] exp_wdata);
    exp_t e, got_e;
    bit got;
    logic [31:0] exp_waddr;
    exp_waddr = (addr & 32'h0001_FFFC) >> 2;
    n_rd = 0; n_wr = 0;
    @(negedge clk);
    chk({tag, ".ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_rd     = rd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    e.rdata = exp_rdata; e.rd = rd; e.fault = exp_fault; e.faddr = addr; e.cyc = cyc + lat - 1;
    sbq.push_back(e);
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      sample_strobes();
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        got_e = sbq.pop_front();
        chk({tag, ".rdata"}, bus.rsp_rdata, got_e.rdata);
        chk({tag, ".rd"}, {27'd0, bus.rsp_rd}, {27'd0, got_e.rd});
        chk({tag, ".fault"}, {31'd0, bus.rsp_fault}, {31'd0, got_e.fault});
        if (got_e.fault) chk({tag, ".fault_addr"}, bus.fault_addr, got_e.faddr);
        chk({tag, ".latency_cycle"}, cyc, got_e.cyc);
      end
    end
    if (!got) begin
      chk({tag, ".rsp_timeout"}, 32'd0, 32'd1);
      void'(sbq.pop_front());
    end
    chk({tag, ".n_reads"}, n_rd, exp_nrd);
    chk({tag, ".n_writes"}, n_wr, exp_nwr);
    if (exp_nrd > 0) begin
      chk({tag, ".rmem"}, {27'd0, last_rmem}, {27'd0, exp_rmem});
      chk({tag, ".raddr"}, last_raddr, exp_waddr);
    end
    if (exp_nwr > 0) begin
      chk({tag, ".wmem"}, {28'd0, last_wmem}, 32'hF);
      chk({tag, ".waddr"}, last_waddr, exp_waddr);
      chk({tag, ".wdata"}, last_wdata, exp_wdata);
    end
    $display("txn %s we=%0d f3=%0d addr=%h rdata=%h fault=%0d", tag, we, f3, addr,
             bus.rsp_rdata, bus.rsp_fault);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    chk({tag, ".rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, ".wmem"}, {28'd0, bus.wmem}, 32'd0);
    chk({tag, ".rmem"}, {27'd0, bus.rmem}, 32'd0);
    chk({tag, ".mem_addr"}, bus.mem_addr, 32'd0);
    chk({tag, ".store_data"}, bus.store_data, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_rd     = 5'd0;

    // Reset asserted mid-cycle: outputs clear immediately.
    #12 rst_n = 1'b0;
    #1;
    chk_idle_outputs("reset");
    chk("reset.rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset.rsp_rd", {27'd0, bus.rsp_rd}, 32'd0);
    chk("reset.rsp_fault", {31'd0, bus.rsp_fault}, 32'd0);
    chk("reset.fault_addr", bus.fault_addr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    n_rd = 0; n_wr = 0;
    repeat (3) begin
      @(negedge clk);
      sample_strobes();
    end
    chk("post_reset.strobes", n_rd + n_wr, 32'd0);

    // SW then LW
    xact("sw_100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 32'd0, 1'b0, 2, 0, 5'd0, 1, 32'hDEADBEEF);
    chk("sw_100.mem", mem[8'h40], 32'hDEADBEEF);
    xact("lw_100", 1'b0, 3'b010, 32'h100, 32'd0, 5'd2, 32'hDEADBEEF, 1'b0, 2, 1, 5'b01111, 0, 32'd0);

    // SB read-modify-write and byte loads
    xact("sb_103", 1'b1, 3'b000, 32'h103, 32'h0000005A, 5'd3, 32'd0, 1'b0, 3, 1, 5'b01111, 1, 32'h5AADBEEF);
    chk("sb_103.mem", mem[8'h40], 32'h5AADBEEF);
    xact("lb_103", 1'b0, 3'b000, 32'h103, 32'd0, 5'd4, 32'h0000005A, 1'b0, 2, 1, 5'b11000, 0, 32'd0);
    xact("lb_101", 1'b0, 3'b000, 32'h101, 32'd0, 5'd5, 32'hFFFFFFBE, 1'b0, 2, 1, 5'b10010, 0, 32'd0);
    xact("lbu_101", 1'b0, 3'b100, 32'h101, 32'd0, 5'd6, 32'h000000BE, 1'b0, 2, 1, 5'b00010, 0, 32'd0);

    // SH read-modify-write and halfword loads
    xact("sh_102", 1'b1, 3'b001, 32'h102, 32'h00001234, 5'd7, 32'd0, 1'b0, 3, 1, 5'b01111, 1, 32'h1234BEEF);
    chk("sh_102.mem", mem[8'h40], 32'h1234BEEF);
    xact("lh_100", 1'b0, 3'b001, 32'h100, 32'd0, 5'd8, 32'hFFFFBEEF, 1'b0, 2, 1, 5'b10011, 0, 32'd0);
    xact("lhu_100", 1'b0, 3'b101, 32'h100, 32'd0, 5'd9, 32'h0000BEEF, 1'b0, 2, 1, 5'b00011, 0, 32'd0);
    xact("lh_102", 1'b0, 3'b001, 32'h102, 32'd0, 5'd10, 32'h00001234, 1'b0, 2, 1, 5'b11100, 0, 32'd0);

    // Faults: no strobes, memory unchanged
    xact("flt_lw_102", 1'b0, 3'b010, 32'h102, 32'd0, 5'd11, 32'd0, 1'b1, 1, 0, 5'd0, 0, 32'd0);
    xact("flt_sh_101", 1'b1, 3'b001, 32'h101, 32'hFFFF, 5'd12, 32'd0, 1'b1, 1, 0, 5'd0, 0, 32'd0);
    xact("flt_ld_f3_3", 1'b0, 3'b011, 32'h100, 32'd0, 5'd13, 32'd0, 1'b1, 1, 0, 5'd0, 0, 32'd0);
    xact("flt_st_f3_4", 1'b1, 3'b100, 32'h104, 32'h1, 5'd14, 32'd0, 1'b1, 1, 0, 5'd0, 0, 32'd0);
    chk("faults.mem", mem[8'h40], 32'h1234BEEF);

    // Address bits above the implemented range alias onto the same word
    xact("lw_alias", 1'b0, 3'b010, 32'h0002_0100, 32'd0, 5'd15, 32'h1234BEEF, 1'b0, 2, 1, 5'b01111, 0, 32'd0);

    // Reset during RMW_RD abandons the store
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h100;
    bus.req_wdata  = 32'h000000AA;
    bus.req_rd     = 5'd16;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("rmw_rst.in_rmw_rd", {27'd0, bus.rmem}, 32'b01111);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("rmw_rst");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rmw_rst.mem", mem[8'h40], 32'h1234BEEF);
    chk("rmw_rst.wmem_idle", {28'd0, bus.wmem}, 32'd0);
    xact("lw_after_rst", 1'b0, 3'b010, 32'h100, 32'd0, 5'd17, 32'h1234BEEF, 1'b0, 2, 1, 5'b01111, 0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
